// File: rtl/vx_index_retire_queue.sv
// ---------------------------------------------------------------------------
// vx_index_retire_queue
//
// Allocate-in-order / release-out-of-order / retire-in-order index queue.
// A push takes the entry at the tail and returns its index. Any release port
// may later mark that index done, in any order. The head entry retires once it
// is done and the consumer accepts it, so entries leave strictly in allocation
// order. Payloads can also be read at random through rd_idx.
//
// Parameters
//   DATAW    payload width in bits
//   SIZE     entry count (power of two, >= 2)
//   NUM_RELS number of independent release ports (>= 1)
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   flush           (only with VX_INDEX_RETIRE_QUEUE_FLUSH_EN) clears control state
//   push_valid/ready, push_data, push_idx   allocation handshake and assigned index
//   rel_valid[p], rel_idx[p*IW +: IW]       per-port release of an allocated index
//   rd_idx -> rd_data                       combinational random-access read
//   ret_valid/ready, ret_idx, ret_data      in-order retire of the head entry
//   count                                   number of allocated entries
//
// Optional feature macro: VX_INDEX_RETIRE_QUEUE_FLUSH_EN
// ---------------------------------------------------------------------------
module vx_index_retire_queue #(
  parameter int DATAW    = 1,
  parameter int SIZE     = 4,
  parameter int NUM_RELS = 1,
  localparam int IW      = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int CW      = $clog2(SIZE + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef VX_INDEX_RETIRE_QUEUE_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   push_valid,
  input  logic [DATAW-1:0]       push_data,
  output logic                   push_ready,
  output logic [IW-1:0]          push_idx,
  input  logic [NUM_RELS-1:0]    rel_valid,
  input  logic [NUM_RELS*IW-1:0] rel_idx,
  input  logic [IW-1:0]          rd_idx,
  output logic [DATAW-1:0]       rd_data,
  output logic                   ret_valid,
  input  logic                   ret_ready,
  output logic [IW-1:0]          ret_idx,
  output logic [DATAW-1:0]       ret_data,
  output logic [CW-1:0]          count
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [IW:0]       head;
  logic [IW:0]       tail;
  logic [SIZE-1:0]   alloc;
  logic [SIZE-1:0]   done;
  logic [DATAW-1:0]  entries [SIZE];

  logic              clear;
  logic              empty;
  logic              full;
  logic              push_fire;
  logic              ret_fire;
  logic [IW-1:0]     head_l;
  logic [IW-1:0]     tail_l;

`ifdef VX_INDEX_RETIRE_QUEUE_FLUSH_EN
  assign clear = reset | flush;
`else
  assign clear = reset;
`endif

  assign head_l = head[IW-1:0];
  assign tail_l = tail[IW-1:0];
  assign empty  = (head == tail);
  assign full   = (head_l == tail_l) && (head[IW] != tail[IW]);

  // push_ready looks at registered state only; a retire in the same cycle
  // frees the slot for the following cycle, never the current one.
  assign push_ready = ~full;
  assign push_idx   = tail_l;
  assign push_fire  = push_valid & push_ready & ~clear;

  assign ret_valid  = ~empty & done[head_l];
  assign ret_idx    = head_l;
  assign ret_data   = entries[head_l];
  assign ret_fire   = ret_valid & ret_ready & ~clear;

  assign rd_data    = entries[rd_idx];
  assign count      = CW'(tail - head);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      head  <= '0;
      tail  <= '0;
      alloc <= '0;
      done  <= '0;
    end else begin
      // Releases are plain sets, so several ports naming one index are idempotent.
      for (int p = 0; p < NUM_RELS; p++) begin
        if (rel_valid[p]) begin
          done[rel_idx[p*IW +: IW]] <= 1'b1;
        end
      end
      if (push_fire) begin
        alloc[tail_l] <= 1'b1;
        done[tail_l]  <= 1'b0;
        tail          <= tail + 1'b1;
      end
      if (ret_fire) begin
        alloc[head_l] <= 1'b0;
        done[head_l]  <= 1'b0;
        head          <= head + 1'b1;
      end
    end
  end

  // NOTE: the payload array is deliberately left out of reset; only the
  // control state decides which entries are meaningful, and an unreset array
  // maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      entries[tail_l] <= push_data;
    end
  end

`ifndef SYNTHESIS
  // Runtime checks on release usage; inactive while control state is cleared.
  always @(posedge clk) begin
    if (!clear) begin
      for (int p = 0; p < NUM_RELS; p++) begin
        if (rel_valid[p]) begin
          assert (alloc[rel_idx[p*IW +: IW]] && !done[rel_idx[p*IW +: IW]])
            else $error("release of unallocated or already-done index %0d", rel_idx[p*IW +: IW]);
          assert (!(push_fire && (rel_idx[p*IW +: IW] == tail_l)))
            else $error("release of index %0d while it is being pushed", tail_l);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_vx_index_retire_queue.sv
// ---------------------------------------------------------------------------
// tb_vx_index_retire_queue
//
// Directed bench for vx_index_retire_queue (SIZE=4, NUM_RELS=2, DATAW=8).
// A small reference model tracks head, tail, count and done flags; pushed
// entries go into a scoreboard queue and are popped when a retire is expected.
// Build with VX_INDEX_RETIRE_QUEUE_FLUSH_EN defined to also cover flush.
// ---------------------------------------------------------------------------
module tb_vx_index_retire_queue;

  localparam int DATAW    = 8;
  localparam int SIZE     = 4;
  localparam int NUM_RELS = 2;
  localparam int IW       = 2;
  localparam int CW       = 3;

  typedef struct {
    logic [IW-1:0]    idx;
    logic [DATAW-1:0] data;
  } sb_entry_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   flush_i;
  logic                   push_valid;
  logic [DATAW-1:0]       push_data;
  logic                   push_ready;
  logic [IW-1:0]          push_idx;
  logic [NUM_RELS-1:0]    rel_valid;
  logic [NUM_RELS*IW-1:0] rel_idx;
  logic [IW-1:0]          rd_idx;
  logic [DATAW-1:0]       rd_data;
  logic                   ret_valid;
  logic                   ret_ready;
  logic [IW-1:0]          ret_idx;
  logic [DATAW-1:0]       ret_data;
  logic [CW-1:0]          count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  sb_entry_t       sb[$];
  logic [IW-1:0]   m_head;
  logic [IW-1:0]   m_tail;
  int              m_count;
  logic [SIZE-1:0] m_done;

  always #5 clk = ~clk;

  vx_index_retire_queue #(
    .DATAW    (DATAW),
    .SIZE     (SIZE),
    .NUM_RELS (NUM_RELS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef VX_INDEX_RETIRE_QUEUE_FLUSH_EN
    .flush      (flush_i),
`endif
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .push_idx   (push_idx),
    .rel_valid  (rel_valid),
    .rel_idx    (rel_idx),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .ret_valid  (ret_valid),
    .ret_ready  (ret_ready),
    .ret_idx    (ret_idx),
    .ret_data   (ret_data),
    .count      (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_head  = '0;
    m_tail  = '0;
    m_count = 0;
    m_done  = '0;
    sb.delete();
  endtask

  // One clock cycle: compare current outputs with the model, account for the
  // handshakes the current inputs make, step the clock, then advance the model.
  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic cycle();
    logic                   exp_rv;
    logic                   clr;
    logic                   do_push;
    logic                   do_ret;
    logic [NUM_RELS-1:0]    rv;
    logic [NUM_RELS*IW-1:0] ri;
    sb_entry_t              e;

    exp_rv = (m_count != 0) && m_done[m_head];
    check("ret_valid", ret_valid, exp_rv);
    check("push_ready", push_ready, m_count != SIZE);
    check("count", count, m_count);

    clr     = reset || flush_i;
    rv      = rel_valid;
    ri      = rel_idx;
    do_push = !clr && push_valid && (m_count != SIZE);
    do_ret  = !clr && ret_ready && exp_rv;

    if (do_ret) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_underflow observed retire expected none");
      end else begin
        e = sb.pop_front();
        check("ret_idx", ret_idx, e.idx);
        check("ret_data", ret_data, e.data);
      end
    end
    if (do_push) begin
      check("push_idx", push_idx, m_tail);
      sb.push_back('{idx: m_tail, data: push_data});
    end

    @(posedge clk);
    #1;

    if (clr) begin
      model_clear();
    end else begin
      for (int p = 0; p < NUM_RELS; p++) begin
        if (rv[p]) m_done[ri[p*IW +: IW]] = 1'b1;
      end
      if (do_push) begin
        m_done[m_tail] = 1'b0;
        m_tail         = m_tail + 1'b1;
      end
      if (do_ret) begin
        m_done[m_head] = 1'b0;
        m_head         = m_head + 1'b1;
      end
      m_count = m_count + int'(do_push) - int'(do_ret);
    end
  endtask

  task automatic idle();
    push_valid = 1'b0;
    rel_valid  = '0;
    ret_ready  = 1'b0;
  endtask

  task automatic push(input logic [DATAW-1:0] d);
    idle();
    push_valid = 1'b1;
    push_data  = d;
    cycle();
    push_valid = 1'b0;
  endtask

  task automatic release1(input logic [IW-1:0] idx, input logic rr);
    idle();
    rel_valid = 2'b01;
    rel_idx   = {2'd0, idx};
    ret_ready = rr;
    cycle();
    rel_valid = '0;
  endtask

  initial begin
    reset      = 1'b1;
    flush_i    = 1'b0;
    push_data  = '0;
    rel_idx    = '0;
    rd_idx     = '0;
    idle();
    model_clear();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("reset_count", count, 0);
    check("reset_ret_valid", ret_valid, 0);
    check("reset_push_ready", push_ready, 1);
    check("reset_push_idx", push_idx, 0);

    // Fill: indices 0..3, then full with nothing released
    push(8'hA0);
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    check("full_count", count, 4);
    check("full_push_ready", push_ready, 0);
    check("full_ret_valid", ret_valid, 0);
    rd_idx = 2'd2;
    #1;
    check("rd_data_2", rd_data, 8'hA2);

    // Head released, consumer stalls for 5 cycles: outputs hold
    release1(2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("hold_ret_idx", ret_idx, 0);
      check("hold_ret_data", ret_data, 8'hA0);
      cycle();
    end

    // Full + push + retire together: push rejected, retire proceeds
    idle();
    push_valid = 1'b1;
    push_data  = 8'hA4;
    ret_ready  = 1'b1;
    cycle();
    check("after_retire_count", count, 3);
    check("after_retire_push_ready", push_ready, 1);
    push(8'hA4);
    check("wrap_count", count, 4);
    rd_idx = 2'd0;
    #1;
    check("rd_data_wrap", rd_data, 8'hA4);

    // Out-of-order release: 3 then 1; only 1 retires, then 2 and 3 back to back
    release1(2'd3, 1'b1);
    release1(2'd1, 1'b1);
    ret_ready = 1'b1;
    cycle();
    check("stall_on_2", ret_valid, 0);
    release1(2'd2, 1'b1);
    ret_ready = 1'b1;
    cycle();
    cycle();
    check("after_ooo_count", count, 1);

    // Both release ports name the head index in the same cycle
    idle();
    rel_valid = 2'b11;
    rel_idx   = {2'd0, 2'd0};
    cycle();
    idle();
    ret_ready = 1'b1;
    cycle();
    cycle();
    check("dual_release_count", count, 0);
    check("dual_release_ret_valid", ret_valid, 0);

    // Reset mid-operation with activity on every input
    push(8'hB0);
    push(8'hB1);
    release1(2'd1, 1'b0);
    idle();
    reset      = 1'b1;
    push_valid = 1'b1;
    push_data  = 8'hEE;
    rel_valid  = 2'b01;
    rel_idx    = {2'd0, 2'd2};
    ret_ready  = 1'b1;
    cycle();
    reset = 1'b0;
    idle();
    check("midreset_count", count, 0);
    check("midreset_push_ready", push_ready, 1);
    check("midreset_push_idx", push_idx, 0);
    check("midreset_ret_valid", ret_valid, 0);
    push(8'hC0);
    release1(2'd0, 1'b0);
    ret_ready = 1'b1;
    cycle();
    idle();
    cycle();

`ifdef VX_INDEX_RETIRE_QUEUE_FLUSH_EN
    // Flush with a push in the same cycle
    push(8'hD0);
    push(8'hD1);
    push(8'hD2);
    check("preflush_count", count, 3);
    idle();
    flush_i    = 1'b1;
    push_valid = 1'b1;
    push_data  = 8'hDD;
    cycle();
    flush_i = 1'b0;
    idle();
    check("flush_count", count, 0);
    check("flush_push_idx", push_idx, 0);
    check("flush_ret_valid", ret_valid, 0);
    check("flush_push_ready", push_ready, 1);
    cycle();
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_index_retire_queue.md
VX_INDEX_RETIRE_QUEUE -- requirements
Module: VX_index_retire_queue

Interface
REQ-001 SHALL have parameter DATAW, default 1: payload width in bits.
REQ-002 SHALL have parameter SIZE, default 4: entry count, power of two, >= 2; IW = LOG2UP(SIZE).
REQ-003 SHALL have parameter NUM_RELS, default 1: number of independent release ports, >= 1.
REQ-004 SHALL use clock clk; reset is reset, synchronous, active-high.
REQ-005 clk  in  1  clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 push_valid  in  1  allocation request.
REQ-008 push_data  in  DATAW  payload stored on allocation.
REQ-009 push_ready  out  1  free entry available.
REQ-010 push_idx  out  IW  index assigned to the current push.
REQ-011 rel_valid  in  NUM_RELS  per-port release strobe.
REQ-012 rel_idx  in  NUM_RELS*IW  per-port released index, port 0 in LSBs.
REQ-013 rd_idx  in  IW  random-access read index; rd_data  out  DATAW  payload at rd_idx.
REQ-014 ret_valid  out  1  head entry released and ready to retire; ret_ready  in  1  consumer accepts.
REQ-015 ret_idx  out  IW  head index; ret_data  out  DATAW  head payload.
REQ-016 count  out  $clog2(SIZE+1)  number of allocated entries.

Function
REQ-017 Head/tail pointers SHALL be IW+1 bits; empty = pointers equal; full = low bits equal, MSBs differ; wrap modulo SIZE.
REQ-018 push_ready SHALL equal !full from current state only; no same-cycle bypass from a retire.
REQ-019 push fires on push_valid && push_ready: entry[tail] <= push_data, alloc[tail] <= 1, done[tail] <= 0, tail++; push_idx = tail low bits.
REQ-020 Release on port p: done[rel_idx[p]] <= 1 at next edge; several ports naming the same index in one cycle SHALL be idempotent.
REQ-021 Releasing an unallocated or already-done index SHALL fire a RUNTIME_ASSERT; releasing the index being pushed in the same cycle SHALL be illegal (asserted).
REQ-022 ret_valid SHALL be combinational: !empty && done[head]; ret_idx/ret_data SHALL reflect head.
REQ-023 Latency: release at edge t -> earliest ret_valid in cycle after t; push -> earliest release next cycle.
REQ-024 Retire fires on ret_valid && ret_ready: alloc[head] <= 0, done[head] <= 0, head++; entries retire strictly in allocation order regardless of release order.
REQ-025 ret_valid SHALL hold stable with ret_idx/ret_data unchanged until accepted.
REQ-026 count: +1 on push only, -1 on retire only, unchanged on both or neither; never exceeds SIZE.
REQ-027 Push and retire in the same cycle when full: push rejected, retire proceeds, push_ready high next cycle.
REQ-028 rd_data SHALL be combinational entry[rd_idx]; contents of unallocated entries undefined.
REQ-029 Payload storage SHALL not be reset; only control state is reset.

Reset
REQ-030 reset SHALL clear head, tail, alloc, done: count 0, ret_valid 0, push_ready 1, push_idx 0.
REQ-031 Reset mid-operation SHALL discard all entries; push/release/retire in the reset cycle SHALL be ignored.

Configuration
REQ-032 Macro VX_INDEX_RETIRE_QUEUE_FLUSH_EN SHALL add input port flush (1 bit).
REQ-033 With the macro: flush SHALL act as reset of control state at next edge; same-cycle push, release and retire ignored; push_ready 1 and count 0 next cycle.
REQ-034 Without the macro: no flush port; entries leave only via retire.

Verification
REQ-035 SIZE=4: 4 pushes D0..D3 -> push_idx 0,1,2,3; count 4; push_ready 0; ret_valid 0.
REQ-036 Release idx 2 then 0, ret_ready=1 -> retire idx 0 (D0) only; after release 1, retires 1 then 2 on consecutive cycles.
REQ-037 NUM_RELS=2, both ports release idx 1 same cycle -> done[1] set once, no assertion, single retire.
REQ-038 Full queue, head released, push_valid+ret_ready same cycle -> push rejected, count 3, next cycle push gets idx 0 (wrap), count 4.
REQ-039 ret_ready=0 with ret_valid=1 for 5 cycles -> ret_idx/ret_data stable, count unchanged.
REQ-040 FLUSH_EN build, 3 entries, flush=1 with push_valid=1 -> next cycle count 0, push_idx 0, ret_valid 0.
